// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [4:0]  HALT_OPC_DEF = 5'b00000;
  localparam logic [15:0] PC_INC_DEF   = 16'd2;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    HOLD = 2'b01,
    HALT = 2'b10
  } fetch_state_e;

  // Source for the next fetch address.
  typedef enum logic [1:0] {
    PC_KEEP  = 2'b00,
    PC_SEQ   = 2'b01,
    PC_REDIR = 2'b10,
    PC_PEND  = 2'b11
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch address, deferred redirect target and squash flag, with the next-address mux.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     pc_sel,
  input  logic        pend_set,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] seq_pc,
  output logic [15:0] fetch_addr,
  output logic        squash
);

  logic [15:0] pending_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= RESET_PC;
      pending_pc <= RESET_PC;
      squash     <= 1'b0;
    end else begin
      // A later redirect simply overwrites the deferred target.
      if (pend_set) begin
        pending_pc <= redirect_pc;
        squash     <= 1'b1;
      end
      case (pc_sel)
        PC_SEQ:   fetch_addr <= seq_pc;
        PC_REDIR: begin
          fetch_addr <= redirect_pc;
          squash     <= 1'b0;
        end
        PC_PEND:  begin
          fetch_addr <= pending_pc;
          squash     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// hands instructions to decode over valid/ready.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [4:0]  HALT_OPC = HALT_OPC_DEF,
  parameter logic [15:0] PC_INC   = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_inc,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic         gap_q, gap_d;     // one idle cycle after a discarded completion
  logic         drain_q, drain_d; // outstanding request still owed a done in HALT
  pc_sel_e      pc_sel;
  logic         pend_set, latch, clr_valid, set_halt, set_err;
  logic         squash;
  logic [15:0]  fetch_addr;
  logic         redir, misal, busy;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .pend_set    (pend_set),
    .redirect_pc (redirect_pc),
    .seq_pc      (if_pc_inc),
    .fetch_addr  (fetch_addr),
    .squash      (squash)
  );

  assign imem_addr = fetch_addr;
  assign imem_req  = ((state_q == REQ) && !gap_q) || drain_q;
  assign redir     = redirect_valid && (state_q != HALT);
  assign misal     = redir && redirect_pc[0];
  assign busy      = (state_q == REQ) && !gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      gap_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    gap_d     = 1'b0;
    drain_d   = drain_q && !imem_done;
    pc_sel    = PC_KEEP;
    pend_set  = 1'b0;
    latch     = 1'b0;
    clr_valid = 1'b0;
    set_halt  = 1'b0;
    set_err   = 1'b0;

    case (state_q)
      REQ: begin
        if (misal) begin
          state_d  = HALT;
          set_err  = 1'b1;
          set_halt = 1'b1;
          clr_valid = 1'b1;
          drain_d  = busy && !imem_done;
        end else if (redir) begin
          if (!busy) begin
            pc_sel = PC_REDIR;
          end else if (imem_done) begin
            pc_sel = PC_REDIR;
            gap_d  = 1'b1;
          end else begin
            // Address must stay put mid-request; retarget once it completes.
            pend_set = 1'b1;
          end
        end else if (busy && imem_done) begin
          if (squash) begin
            pc_sel = PC_PEND;
            gap_d  = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (misal) begin
          state_d   = HALT;
          set_err   = 1'b1;
          set_halt  = 1'b1;
          clr_valid = 1'b1;
        end else if (redir) begin
          clr_valid = 1'b1;
          pc_sel    = PC_REDIR;
          state_d   = REQ;
        end else if (if_ready) begin
          clr_valid = 1'b1;
          if (if_instr[15:11] == HALT_OPC) begin
            state_d  = HALT;
            set_halt = 1'b1;
          end else begin
            pc_sel  = PC_SEQ;
            state_d = REQ;
          end
        end
      end
      HALT: ;
      default: state_d = REQ;
    endcase
  end

  // NOTE: the output latch is reset explicitly; decode must never see stale
  // X data as a valid instruction after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid  <= 1'b0;
      if_instr  <= 16'h0000;
      if_pc     <= 16'h0000;
      if_pc_inc <= 16'h0000;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (latch) begin
        if_valid  <= 1'b1;
        if_instr  <= imem_rdata;
        if_pc     <= fetch_addr;
        if_pc_inc <= fetch_addr + PC_INC;
      end else if (clr_valid) begin
        if_valid  <= 1'b0;
      end
      if (set_halt) halted <= 1'b1;
      if (set_err)  err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table plus hand-written corner sequences.
module tb_fetch_stage;

  localparam logic [15:0] PC_INC = 16'd2;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_inc;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lat;
    int          hold;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc_inc;
  } exp_t;

  vec_t vecs [5];
  exp_t sb [$];

  fetch_stage #(
    .RESET_PC (16'h0000),
    .HALT_OPC (5'b00000),
    .PC_INC   (16'd2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_done      (imem_done),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_inc      (if_pc_inc),
    .halted         (halted),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic [15:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 16) begin
      tick();
      n++;
    end
    check_bit("req_seen", imem_req, 1'b1);
    check("req_addr", imem_addr, exp_addr);
  endtask

  task automatic mem_done(input logic [15:0] data);
    imem_done  = 1'b1;
    imem_rdata = data;
    tick();
    imem_done  = 1'b0;
    imem_rdata = 16'hDEAD;
  endtask

  task automatic accept();
    exp_t e;
    if_ready = 1'b1;
    check_bit("accept_valid", if_valid, 1'b1);
    check_bit("sb_nonempty", sb.size() != 0, 1'b1);
    if (if_valid && sb.size() != 0) begin
      e = sb.pop_front();
      check("if_pc", if_pc, e.pc);
      check("if_instr", if_instr, e.instr);
      check("if_pc_inc", if_pc_inc, e.pc_inc);
    end
    tick();
    if_ready = 1'b0;
  endtask

  task automatic fetch_accept(input int lat, input int hold,
                              input logic [15:0] addr, input logic [15:0] data);
    exp_t e;
    wait_req(addr);
    for (int i = 1; i < lat; i++) begin
      tick();
      check("addr_stable", imem_addr, addr);
      check_bit("req_held", imem_req, 1'b1);
    end
    e.pc     = addr;
    e.instr  = data;
    e.pc_inc = addr + PC_INC;
    sb.push_back(e);
    mem_done(data);
    for (int i = 0; i < hold; i++) begin
      check_bit("hold_valid", if_valid, 1'b1);
      check("hold_pc", if_pc, addr);
      check("hold_instr", if_instr, data);
      check_bit("hold_no_req", imem_req, 1'b0);
      tick();
    end
    accept();
  endtask

  initial begin
    vecs[0] = '{lat: 1, hold: 0, addr: 16'h0000, data: 16'h8001};
    vecs[1] = '{lat: 1, hold: 0, addr: 16'h0002, data: 16'h9002};
    vecs[2] = '{lat: 2, hold: 0, addr: 16'h0004, data: 16'hA004};
    vecs[3] = '{lat: 3, hold: 5, addr: 16'h0006, data: 16'hB806};
    vecs[4] = '{lat: 1, hold: 0, addr: 16'h0008, data: 16'hC008};

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    imem_rdata     = 16'h0000;
    imem_done      = 1'b0;
    if_ready       = 1'b0;
    tick();
    tick();

    check_bit("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 16'h0000);
    check("rst_if_pc", if_pc, 16'h0000);
    check("rst_if_pc_inc", if_pc_inc, 16'h0000);
    check_bit("rst_halted", halted, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check("rst_addr", imem_addr, 16'h0000);
    rst_n = 1'b1;

    // Sequential fetch, including a long HOLD and multi-cycle latency.
    foreach (vecs[i]) fetch_accept(vecs[i].lat, vecs[i].hold, vecs[i].addr, vecs[i].data);

    // Redirect while 0x000A is outstanding: address held, data discarded.
    wait_req(16'h000A);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("squash_addr_hold1", imem_addr, 16'h000A);
    tick();
    check("squash_addr_hold2", imem_addr, 16'h000A);
    mem_done(16'h700A);
    check_bit("squash_gap_req", imem_req, 1'b0);
    check_bit("squash_no_valid", if_valid, 1'b0);
    fetch_accept(1, 0, 16'h0040, 16'hD040);

    // Redirect in the same cycle as accept: held instruction dropped.
    wait_req(16'h0042);
    mem_done(16'hE042);
    check_bit("hold_redir_valid", if_valid, 1'b1);
    check("hold_redir_pc", if_pc, 16'h0042);
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick();
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    check_bit("hold_redir_dropped", if_valid, 1'b0);
    fetch_accept(2, 0, 16'h0080, 16'hF080);

    // Redirect coinciding with done, then sequential wrap at 0xFFFE.
    wait_req(16'h0082);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    mem_done(16'h7082);
    redirect_valid = 1'b0;
    check_bit("done_redir_gap", imem_req, 1'b0);
    check_bit("done_redir_no_valid", if_valid, 1'b0);
    fetch_accept(1, 0, 16'hFFFE, 16'h8FFE);
    fetch_accept(1, 0, 16'h0000, 16'h9000);
    fetch_accept(1, 0, 16'h0002, 16'h9802);
    fetch_accept(2, 0, 16'h0004, 16'hA804);

    // HALT opcode at 0x0006: fetch stops and ignores redirects.
    fetch_accept(1, 0, 16'h0006, 16'h0000);
    check_bit("halt_halted", halted, 1'b1);
    check_bit("halt_no_valid", if_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 5);
      redirect_pc    = 16'h0100;
      check_bit("halt_no_req", imem_req, 1'b0);
      tick();
    end
    redirect_valid = 1'b0;
    check_bit("halt_sticky", halted, 1'b1);
    check_bit("halt_no_err", err, 1'b0);

    // Asynchronous reset out of HALT, then refetch from RESET_PC.
    rst_n = 1'b0;
    #1;
    check_bit("rst2_halted", halted, 1'b0);
    check("rst2_addr", imem_addr, 16'h0000);
    tick();
    rst_n = 1'b1;
    fetch_accept(1, 0, 16'h0000, 16'h8100);

    // Misaligned redirect with a request outstanding: it drains, then silence.
    wait_req(16'h0002);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0031;
    tick();
    redirect_valid = 1'b0;
    check_bit("mis_err", err, 1'b1);
    check_bit("mis_halted", halted, 1'b1);
    check_bit("mis_drain_req", imem_req, 1'b1);
    check("mis_drain_addr", imem_addr, 16'h0002);
    tick();
    check_bit("mis_drain_req2", imem_req, 1'b1);
    mem_done(16'h8202);
    check_bit("mis_req_dropped", imem_req, 1'b0);
    check_bit("mis_no_valid", if_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_bit("mis_no_req", imem_req, 1'b0);
      tick();
    end
    check_bit("mis_no_valid_end", if_valid, 1'b0);
    check_bit("sb_empty", sb.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
